accumulator_control_unit: RTL

- Fetch/decode/execute sequencer for the 16-bit accumulator computer.
- Drives the write enables and mux selects of the PC, MAR, MBR, IR and ACC registers, plus the ALU opcode and main-memory write enable.
- Sits between the instruction register and the datapath; the datapath top instantiates it as the single controller.
- Instruction format: opcode = IR[15:12], operand address = IR[11:0], skip condition = IR[11:10].

---
 rtl/accumulator_control_unit.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/accumulator_control_unit.sv
// accumulator_control_unit
//   Fetch/decode/execute sequencer for the 16-bit accumulator computer.
//   Drives the PC/MAR/MBR/IR/ACC load enables and source selects, the ALU
//   opcode and the main-memory write enable, and counts retired instructions.
//   Optional feature: define CTRL_SINGLE_STEP_EN to add the `step` input and
//   a PAUSE state that holds the machine between instructions.
module accumulator_control_unit #(
    parameter int OPCODE_W   = 4,
    parameter int COUNT_W    = 16,
    parameter bit AUTO_START = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic [1:0]          ir_skip,
    input  logic                acc_zero,
    input  logic                acc_neg,
    output logic                pc_write,
    output logic [1:0]          pc_sel,
    output logic                mar_write,
    output logic                mar_sel,
    output logic                mbr_write,
    output logic                mbr_sel,
    output logic                ir_write,
    output logic                acc_write,
    output logic [1:0]          acc_sel,
    output logic [3:0]          alu_op,
    output logic                mem_write,
    output logic                halted,
    output logic [COUNT_W-1:0]  instr_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_F3,
        S_DEC,
        S_MRD,
        S_MBR,
        S_EXE,
        S_MWR,
        S_STO,
        S_HALT
`ifdef CTRL_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    // Where an instruction goes after its final cycle.
`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t S_NEXT = S_PAUSE;
`else
    localparam state_t S_NEXT = S_F1;
`endif

    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(4'h0);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(4'h1);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(4'h2);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(4'h3);
    localparam logic [OPCODE_W-1:0] OP_SUBT  = OPCODE_W'(4'h4);
    localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(4'h5);
    localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(4'h6);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(4'h7);
    localparam logic [OPCODE_W-1:0] OP_SKIP  = OPCODE_W'(4'h8);
    localparam logic [OPCODE_W-1:0] OP_JUMP  = OPCODE_W'(4'h9);
    localparam logic [OPCODE_W-1:0] OP_CLEAR = OPCODE_W'(4'hA);
    localparam logic [OPCODE_W-1:0] OP_SHL   = OPCODE_W'(4'hB);
    localparam logic [OPCODE_W-1:0] OP_SHR   = OPCODE_W'(4'hC);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SHL = 4'b0100;
    localparam logic [3:0] ALU_SHR = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_IR   = 2'b01;
    localparam logic [1:0] ACC_ALU = 2'b00;
    localparam logic [1:0] ACC_MBR = 2'b01;
    localparam logic [1:0] ACC_ZRO = 2'b10;

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 skip_true;
    logic                 mem_operand;
    logic                 retire;

    assign instr_count = count_q;

    // SKIPCOND condition selected by IR[11:10]; 11 never skips.
    always_comb begin
        skip_true = 1'b0;
        case (ir_skip)
            2'b00:   skip_true = acc_neg;
            2'b01:   skip_true = acc_zero;
            2'b10:   skip_true = !acc_neg && !acc_zero;
            default: skip_true = 1'b0;
        endcase
    end

    // Opcodes that fetch an operand from memory before EXE.
    always_comb begin
        mem_operand = 1'b0;
        case (ir_opcode)
            OP_LOAD, OP_ADD, OP_SUBT, OP_AND, OP_OR: mem_operand = 1'b1;
            default:                                 mem_operand = 1'b0;
        endcase
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start || AUTO_START) state_d = S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   state_d = S_F3;
            S_F3:   state_d = S_DEC;
            S_DEC: begin
                if (mem_operand)               state_d = S_MRD;
                else if (ir_opcode == OP_STORE) state_d = S_MWR;
                else if (ir_opcode == OP_HALT)  state_d = S_HALT;
                else                            state_d = S_NEXT;
            end
            S_MRD:  state_d = S_MBR;
            S_MBR:  state_d = S_EXE;
            S_EXE:  state_d = S_NEXT;
            S_MWR:  state_d = S_STO;
            S_STO:  state_d = S_NEXT;
            S_HALT: state_d = S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
            S_PAUSE: if (step) state_d = S_F1;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // An instruction retires on the cycle that leaves it for the next fetch
    // (or for HALT); IDLE->F1 and PAUSE->F1 are not retirements.
    always_comb begin
        retire = 1'b0;
        if (state_q == S_DEC || state_q == S_EXE || state_q == S_STO)
            retire = (state_d == S_NEXT) || (state_d == S_HALT);
        count_d = retire ? count_q + COUNT_W'(1) : count_q;
    end

    // Control decode; reset forces every control output low in the same cycle.
    always_comb begin
        pc_write  = 1'b0;
        pc_sel    = PC_INC;
        mar_write = 1'b0;
        mar_sel   = 1'b0;
        mbr_write = 1'b0;
        mbr_sel   = 1'b0;
        ir_write  = 1'b0;
        acc_write = 1'b0;
        acc_sel   = ACC_ALU;
        alu_op    = ALU_ADD;
        mem_write = 1'b0;
        halted    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_F1: begin
                    mar_sel   = 1'b0;
                    mar_write = 1'b1;
                end
                S_F3: begin
                    ir_write = 1'b1;
                    pc_sel   = PC_INC;
                    pc_write = 1'b1;
                end
                S_DEC: begin
                    case (ir_opcode)
                        OP_LOAD, OP_STORE, OP_ADD, OP_SUBT, OP_AND, OP_OR: begin
                            mar_sel   = 1'b1;
                            mar_write = 1'b1;
                        end
                        OP_SKIP: begin
                            pc_sel   = PC_INC;
                            pc_write = skip_true;
                        end
                        OP_JUMP: begin
                            pc_sel   = PC_IR;
                            pc_write = 1'b1;
                        end
                        OP_CLEAR: begin
                            acc_sel   = ACC_ZRO;
                            acc_write = 1'b1;
                        end
                        OP_SHL: begin
                            alu_op    = ALU_SHL;
                            acc_sel   = ACC_ALU;
                            acc_write = 1'b1;
                        end
                        OP_SHR: begin
                            alu_op    = ALU_SHR;
                            acc_sel   = ACC_ALU;
                            acc_write = 1'b1;
                        end
                        // NOP, HALT and the illegal opcodes drive nothing here.
                        default: ;
                    endcase
                end
                S_MBR: begin
                    mbr_sel   = 1'b0;
                    mbr_write = 1'b1;
                end
                S_EXE: begin
                    acc_write = 1'b1;
                    case (ir_opcode)
                        OP_LOAD: acc_sel = ACC_MBR;
                        OP_SUBT: alu_op  = ALU_SUB;
                        OP_AND:  alu_op  = ALU_AND;
                        OP_OR:   alu_op  = ALU_OR;
                        default: alu_op  = ALU_ADD;
                    endcase
                end
                S_MWR: begin
                    mbr_sel   = 1'b1;
                    mbr_write = 1'b1;
                end
                S_STO:  mem_write = 1'b1;
                S_HALT: halted    = 1'b1;
                default: ;
            endcase
        end
    end

    // State and retired-instruction counter; reset wins over the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule
